// File: rtl/dot_acc_pkg.sv
// Shared types and the saturating add used by the dot-product accumulator.
// The add works on a fixed wide container; callers pass their real width.
package dot_acc_pkg;

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam int PROD_W    = 32;
    localparam int MAX_ACC_W = 64;

    // Returns {ovf, sum}. acc must already be sign-extended from acc_w bits.
    // acc_w may range from 32 to MAX_ACC_W-1.
    function automatic logic [MAX_ACC_W:0] sat_add(
        input logic [MAX_ACC_W-1:0] acc,
        input logic [PROD_W-1:0]    prod,
        input int                   acc_w
    );
        logic signed [MAX_ACC_W:0] sum;
        logic signed [MAX_ACC_W:0] max_v;
        logic signed [MAX_ACC_W:0] min_v;
        logic [MAX_ACC_W-1:0]      res;
        logic                      ovf;
        sum   = {acc[MAX_ACC_W-1], acc}
              + {{(MAX_ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
        max_v = ((MAX_ACC_W+1)'(1) << (acc_w - 1)) - (MAX_ACC_W+1)'(1);
        min_v = ~max_v;
        if (sum > max_v) begin
            ovf = 1'b1;
            res = max_v[MAX_ACC_W-1:0];
        end else if (sum < min_v) begin
            ovf = 1'b1;
            res = min_v[MAX_ACC_W-1:0];
        end else begin
            ovf = 1'b0;
            res = sum[MAX_ACC_W-1:0];
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/dot_acc_sat_adder.sv
// Combinational sign-extend, add and clamp of one 32-bit product into an
// ACC_W-bit signed accumulator.
module dot_acc_sat_adder
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [MAX_ACC_W-1:0] acc_ext;
    logic [MAX_ACC_W:0]   result;
    logic                 unused_hi;

    assign acc_ext   = MAX_ACC_W'($signed(acc));
    assign result    = sat_add(acc_ext, prod, ACC_W);
    assign ovf       = result[MAX_ACC_W];
    assign sum       = result[ACC_W-1:0];
    // Clamped results always fit ACC_W bits; the upper bits are sign copies.
    assign unused_hi = ^result[MAX_ACC_W-1:ACC_W];

endmodule

// File: rtl/dot_accumulator.sv
// Accumulates a stream of signed products into one saturated dot-product
// result per vector, with valid/ready on both sides.
module dot_accumulator
    import dot_acc_pkg::*;
#(
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 40,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accept;
    logic               is_last;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic [CNT_W-1:0]   count_inc;

    dot_acc_sat_adder #(.ACC_W(ACC_W)) u_adder (
        .acc  (acc_q),
        .prod (in_prod),
        .sum  (add_sum),
        .ovf  (add_ovf)
    );

    // clr blocks acceptance in the same cycle it aborts the vector.
    assign in_ready  = (state_q == ACCUM) && !clr;
    assign accept    = in_valid && in_ready;
    assign count_inc = count_q + CNT_W'(1);
    assign is_last   = in_last || (count_q == CNT_W'(VEC_LEN - 1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ACCUM: begin
                if (clr) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (accept) begin
                    acc_d   = add_sum;
                    count_d = count_inc;
                    ovf_d   = ovf_q | add_ovf;
                    if (is_last) begin
                        out_sum_d   = add_sum;
                        out_count_d = count_inc;
                        out_ovf_d   = ovf_q | add_ovf;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = ACCUM;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    count_d     = '0;
                    ovf_d       = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dot_accumulator.sv
// Three accumulator configurations share one stimulus bus; sel picks the
// instance that sees in_valid. Results are checked against a scoreboard.
module tb_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    int          sel = 0;

    logic        in_ready_w  [3];
    logic        out_valid_w [3];
    logic        ovf_w       [3];
    logic [63:0] sum_w       [3];
    logic [7:0]  cnt_w       [3];

    always #5 clk = ~clk;

    // Instance 0: VEC_LEN 4 / 40 bit, 1: VEC_LEN 5 / 40 bit, 2: VEC_LEN 4 / 33 bit
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int VLG = (gi == 1) ? 5 : 4;
        localparam int AWG = (gi == 2) ? 33 : 40;
        localparam int CWG = $clog2(VLG + 1);
        logic [AWG-1:0] s;
        logic [CWG-1:0] c;
        dot_accumulator #(.VEC_LEN(VLG), .ACC_W(AWG)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .in_valid  (in_valid && (sel == gi)),
            .in_ready  (in_ready_w[gi]),
            .in_prod   (in_prod),
            .in_last   (in_last),
            .out_valid (out_valid_w[gi]),
            .out_ready (out_ready),
            .out_sum   (s),
            .out_count (c),
            .out_ovf   (ovf_w[gi])
        );
        assign sum_w[gi] = 64'($signed(s));
        assign cnt_w[gi] = 8'(c);
    end

    typedef struct {
        logic [63:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          sel;
        logic [31:0] prod;
        logic        last;
        logic        push;
        logic [63:0] esum;
        logic [7:0]  ecnt;
        logic        eovf;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_result(input logic [63:0] s, input logic [7:0] c, input logic o);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.ovf = o;
        exp_q.push_back(e);
    endtask

    task automatic send(input int s, input logic [31:0] p, input logic l);
        logic took;
        int   guard;
        took  = 1'b0;
        guard = 0;
        while (!took && guard < 50) begin
            @(negedge clk);
            sel = s; in_prod = p; in_last = l; in_valid = 1'b1;
            took = in_ready_w[s];
            @(posedge clk);
            guard++;
        end
        if (!took) chk("send_timeout", 64'(took), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic add_vec(input int s, input logic [31:0] p, input logic l, input logic push,
                           input logic [63:0] es, input logic [7:0] ec, input logic eo);
        vec_t v;
        v.sel = s; v.prod = p; v.last = l; v.push = push;
        v.esum = es; v.ecnt = ec; v.eovf = eo;
        tbl.push_back(v);
    endtask

    // Scoreboard: a result is consumed when out_valid & out_ready before an edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid_w[sel] && out_ready) begin
                chk("scoreboard_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_sum", sum_w[sel], e.sum);
                    chk("out_count", 64'(cnt_w[sel]), 64'(e.cnt));
                    chk("out_ovf", 64'(ovf_w[sel]), 64'(e.ovf));
                    $display("result dut%0d sum=0x%0h count=%0d ovf=%0d", sel, sum_w[sel], cnt_w[sel], ovf_w[sel]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int prev_sel;
        // Basic 1..4, terminated by count (no in_last)
        add_vec(0, 32'd1, 0, 0, 0, 0, 0);
        add_vec(0, 32'd2, 0, 0, 0, 0, 0);
        add_vec(0, 32'd3, 0, 0, 0, 0, 0);
        add_vec(0, 32'd4, 0, 1, 64'd10, 8'd4, 0);
        // Early termination, then a fresh vector
        add_vec(0, 32'd5, 0, 0, 0, 0, 0);
        add_vec(0, 32'd7, 1, 1, 64'd12, 8'd2, 0);
        add_vec(0, 32'd9, 1, 1, 64'd9, 8'd1, 0);
        // Signed: -1 x4 + 1 over VEC_LEN 5
        add_vec(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        add_vec(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        add_vec(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        add_vec(1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        add_vec(1, 32'h0000_0001, 0, 1, 64'hFFFF_FFFF_FFFF_FFFD, 8'd5, 0);
        // Single-element vector and a mixed-sign vector
        add_vec(1, 32'd100, 1, 1, 64'd100, 8'd1, 0);
        add_vec(1, 32'hFFFF_FFFB, 0, 0, 0, 0, 0);
        add_vec(1, 32'd20, 0, 0, 0, 0, 0);
        add_vec(1, 32'hFFFF_FF9C, 1, 1, 64'hFFFF_FFFF_FFFF_FFAB, 8'd3, 0);
        // 33-bit saturation at both rails
        add_vec(2, 32'h7FFF_FFFF, 0, 0, 0, 0, 0);
        add_vec(2, 32'h7FFF_FFFF, 0, 0, 0, 0, 0);
        add_vec(2, 32'h7FFF_FFFF, 0, 0, 0, 0, 0);
        add_vec(2, 32'h7FFF_FFFF, 0, 1, 64'h0000_0000_FFFF_FFFF, 8'd4, 1);
        add_vec(2, 32'h8000_0000, 0, 0, 0, 0, 0);
        add_vec(2, 32'h8000_0000, 0, 0, 0, 0, 0);
        add_vec(2, 32'h8000_0000, 0, 0, 0, 0, 0);
        add_vec(2, 32'h8000_0000, 0, 1, 64'hFFFF_FFFF_0000_0000, 8'd4, 1);
        // Clamped value carries forward; ovf stays sticky; redundant in_last
        add_vec(2, 32'h7FFF_FFFF, 0, 0, 0, 0, 0);
        add_vec(2, 32'h7FFF_FFFF, 0, 0, 0, 0, 0);
        add_vec(2, 32'h7FFF_FFFF, 0, 0, 0, 0, 0);
        add_vec(2, 32'h8000_0000, 1, 1, 64'h0000_0000_7FFF_FFFF, 8'd4, 1);

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid_w[0]), 64'd0);
        chk("rst_out_sum", sum_w[0], 64'd0);
        chk("rst_out_count", 64'(cnt_w[0]), 64'd0);
        chk("rst_out_ovf", 64'(ovf_w[0]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) chk("rst_in_ready", 64'(in_ready_w[i]), 64'd1);

        // Vector table
        prev_sel = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].sel != prev_sel) idle(3);
            prev_sel = tbl[i].sel;
            if (tbl[i].push) expect_result(tbl[i].esum, tbl[i].ecnt, tbl[i].eovf);
            $display("vec %0d: dut%0d prod=0x%08h last=%0d", i, tbl[i].sel, tbl[i].prod, tbl[i].last);
            send(tbl[i].sel, tbl[i].prod, tbl[i].last);
        end
        idle(3);

        // Latency and single bubble
        expect_result(64'd10, 8'd4, 0);
        send(0, 32'd1, 0);
        send(0, 32'd2, 0);
        send(0, 32'd3, 0);
        #1 chk("lat_valid_before_last", 64'(out_valid_w[0]), 64'd0);
        send(0, 32'd4, 0);
        #1;
        chk("lat_out_valid", 64'(out_valid_w[0]), 64'd1);
        chk("lat_in_ready_low", 64'(in_ready_w[0]), 64'd0);
        idle(1);
        @(posedge clk);
        #1;
        chk("lat_out_valid_drop", 64'(out_valid_w[0]), 64'd0);
        chk("lat_in_ready_back", 64'(in_ready_w[0]), 64'd1);
        idle(2);

        // Backpressure with an ignored in_valid pulse
        out_ready = 1'b0;
        expect_result(64'd5, 8'd2, 0);
        send(0, 32'd2, 0);
        send(0, 32'd3, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = (i == 1); in_prod = 32'd100; in_last = 1'b1;
            #1;
            chk("bp_out_valid", 64'(out_valid_w[0]), 64'd1);
            chk("bp_out_sum", sum_w[0], 64'd5);
            chk("bp_out_count", 64'(cnt_w[0]), 64'd2);
            chk("bp_out_ovf", 64'(ovf_w[0]), 64'd0);
            chk("bp_in_ready", 64'(in_ready_w[0]), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_out_valid_drop", 64'(out_valid_w[0]), 64'd0);
        expect_result(64'd9, 8'd1, 0);
        send(0, 32'd9, 1);
        idle(3);

        // clr mid-vector
        expect_result(64'd6, 8'd1, 0);
        send(0, 32'd3, 0);
        send(0, 32'd4, 0);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; in_prod = 32'd50; in_last = 1'b1;
        #1 chk("clr_in_ready", 64'(in_ready_w[0]), 64'd0);
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        send(0, 32'd6, 1);
        idle(3);

        // clr while holding a result is ignored
        out_ready = 1'b0;
        expect_result(64'd2, 8'd2, 0);
        send(0, 32'd1, 0);
        send(0, 32'd1, 1);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        #2;
        chk("clr_hold_valid", 64'(out_valid_w[0]), 64'd1);
        chk("clr_hold_sum", sum_w[0], 64'd2);
        @(negedge clk);
        out_ready = 1'b1;
        idle(3);

        // Async reset between edges, mid-vector
        send(0, 32'd3, 0);
        send(0, 32'd4, 0);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("arst_out_sum", sum_w[0], 64'd0);
        chk("arst_out_count", 64'(cnt_w[0]), 64'd0);
        chk("arst_out_valid", 64'(out_valid_w[0]), 64'd0);
        chk("arst_dut2_sum", sum_w[2], 64'd0);
        chk("arst_dut2_ovf", 64'(ovf_w[2]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2 chk("arst_in_ready", 64'(in_ready_w[0]), 64'd1);
        expect_result(64'd6, 8'd1, 0);
        send(0, 32'd6, 1);
        idle(4);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dot_accumulator.md
Name: dot_accumulator

Overview:
- Downstream stage of the ima16 16x16 multiplier.
- Consumes a stream of 32-bit signed products and accumulates them into a wide signed sum.
- Emits one dot-product result per vector, with a valid/ready handshake on both sides.
- Saturates on overflow and flags it; vector length is a parameter, with early termination via in_last.

Parameters:
- VEC_LEN, 8: maximum products per vector; must be >= 1.
- ACC_W, 40: accumulator/result width in bits, signed; must be >= 32.
- CNT_W, $clog2(VEC_LEN+1): width of the element count.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- clr  in  1  synchronous abort: discards the partial vector.
- in_valid  in  1  product valid.
- in_ready  out  1  block can accept a product.
- in_prod  in  32  signed two's-complement product (ima16 result).
- in_last  in  1  qualifies in_prod as the final element of this vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  signed accumulated sum, saturated.
- out_count  out  CNT_W  number of products in this result.
- out_ovf  out  1  saturation occurred in this vector.

Behaviour:
- Reset (async, rst=1):
  - State goes to ACCUM; acc, count and ovf are cleared.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0, in_ready=1 (once rst deasserts).
  - Reset mid-vector drops the partial sum, and any pending result, without handshake.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1; outputs are registered and stable.
- Accept: an input is accepted when in_valid & in_ready at a rising edge.
  - Sign-extend in_prod to ACC_W+1 bits and add to acc (also sign-extended).
  - If the result exceeds ACC_W signed range, clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and set ovf sticky.
  - count increments.
- ACCUM->HOLD: on an accept where in_last=1 or count==VEC_LEN-1.
  - out_sum, out_count and out_ovf load the final values in that same edge.
  - out_valid=1 in the next cycle, i.e. latency of 1 cycle from the last accept.
- HOLD->ACCUM: on out_valid & out_ready.
  - Clear acc, count and ovf; out_valid=0; in_ready=1 next cycle.
  - There is exactly one bubble cycle between vectors; no same-cycle input accept in HOLD.
- Backpressure: in HOLD, out_sum, out_count and out_ovf are held unchanged indefinitely while out_ready=0.
- clr:
  - In ACCUM, clears acc, count and ovf; any in_valid that cycle is ignored and in_ready is forced to 0 that cycle.
  - In HOLD, clr is ignored; the result must be drained.
- A single product with in_last=1 is a vector of length 1.
- in_last on element VEC_LEN-1 is redundant and harmless.
- in_prod and in_last are don't-care when in_valid=0.
- Overflow is evaluated per add: a later add pulling the value back in range does not clear ovf, and the clamped value is used for subsequent adds.
- No X on outputs after reset.

Decomposition:
- Package dot_acc_pkg:
  - typedef enum logic {ACCUM, HOLD} state_t.
  - Function sat_add(acc, prod) returning the {ovf, sum} pair, parameterised by ACC_W via a localparam in the module.
- Sub-module dot_acc_sat_adder: combinational sign-extend, add and clamp. It is unit-testable in isolation against ima16-style vectors.
- ima16 itself stays outside; the top-level glue connects ima16.result to in_prod.

Test Plan:
- Basic sum: VEC_LEN=4, products 1,2,3,4 back-to-back, out_ready=1.
  - Required: out_valid one cycle after the 4th accept, out_sum=10, out_count=4, out_ovf=0.
  - Required: in_ready=0 for exactly one cycle, then 1.
- Signed values: products 0xFFFFFFFF x4 plus 0x00000001, VEC_LEN=5.
  - Required: out_sum=0xFFFFFFFFFD (-3, 40-bit), out_ovf=0.
- Early termination: products 5, 7 with in_last on the second.
  - Required: out_sum=12, out_count=2.
  - Required: the next vector starts from 0; product 9 with in_last gives out_sum=9.
- Backpressure: out_ready=0 for 3 cycles after out_valid.
  - Required: out_sum, out_count and out_ovf are stable, in_ready=0, and an in_valid pulse is not accepted.
  - Required: when out_ready rises, out_valid drops the next cycle.
- Saturation: ACC_W=33, products 0x7FFFFFFF x4.
  - Required: out_sum=0x0FFFFFFFF (+max), out_ovf=1.
  - Repeat with 0x80000000 x4: out_sum=0x100000000 (-min), out_ovf=1.
- Reset/clr mid-vector: accept 3, 4, then pulse clr, then 6 with in_last.
  - Required: out_sum=6, out_count=1.
  - Repeat with async rst instead of clr, asserted between edges: outputs go to 0 immediately and in_ready=1 once rst deasserts.
